// File: rtl/decoder3to8_pulse.sv
// decoder3to8_pulse: takes 3-bit codes over a valid/ready handshake and
// turns each one into a one-hot 8-bit strobe. The strobe lasts PULSE_LEN
// cycles and is followed by GAP_LEN idle cycles. A one-entry hold register
// lets the next code wait while the current strobe is still running.

module decoder3to8_pulse #(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] code_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic [7:0] Y_out,
   output logic       busy,
   output logic       done
);

   // The counter is only 4 bits wide, so reject any length it cannot hold.
   if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse_len
      $error("decoder3to8_pulse: PULSE_LEN must be in 1..15");
   end
   if (GAP_LEN < 0 || GAP_LEN > 15) begin : g_bad_gap_len
      $error("decoder3to8_pulse: GAP_LEN must be in 0..15");
   end

   localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);
   localparam logic [3:0] GAP_LOAD   = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] count_reg, count_next;
   logic [2:0] active_reg, active_next;
   logic [2:0] hold_reg;
   logic       hold_valid_reg;
   logic [7:0] y_reg, y_next;
   logic       done_reg, done_next;
   logic       accept;
   logic       pop;

   // A code can only be taken when the hold register is empty. Accept and
   // pop can never happen together: one needs hold empty, the other needs it full.
   assign accept = valid_in & ~hold_valid_reg;

   // The hold register is the one-deep queue between the handshake and the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid_reg <= 1'b0;
         hold_reg       <= 3'd0;
      end else if (accept) begin
         hold_valid_reg <= 1'b1;
         hold_reg       <= code_in;
      end else if (pop) begin
         hold_valid_reg <= 1'b0;
      end
   end

   // Next-state logic. Every path into PULSE pops the hold register, so the
   // queued code becomes the active code on the same edge.
   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      active_next = active_reg;
      pop         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (hold_valid_reg) begin
               state_next  = PULSE;
               active_next = hold_reg;
               count_next  = PULSE_LOAD;
               pop         = 1'b1;
            end
         end
         PULSE: begin
            if (count_reg != 4'd0) begin
               count_next = count_reg - 4'd1;
            end else if (GAP_LEN > 0) begin
               state_next = GAP;
               count_next = GAP_LOAD;
            end else if (hold_valid_reg) begin
               // No gap is configured, so the next strobe follows with no zero cycle.
               state_next  = PULSE;
               active_next = hold_reg;
               count_next  = PULSE_LOAD;
               pop         = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         GAP: begin
            if (count_reg != 4'd0) begin
               count_next = count_reg - 4'd1;
            end else if (hold_valid_reg) begin
               state_next  = PULSE;
               active_next = hold_reg;
               count_next  = PULSE_LOAD;
               pop         = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = 4'd0;
         end
      endcase
   end

   // Decode the next strobe one bit at a time. Only one bit can match
   // active_next, so the output is one-hot by construction.
   for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
      assign y_next[gi] = (state_next == PULSE) && (active_next == 3'(gi));
   end

   assign done_next = (state_next == PULSE) && (count_next == 4'd0);

   // State and counter registers. Reset aborts a running strobe at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         count_reg  <= 4'd0;
         active_reg <= 3'd0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         active_reg <= active_next;
      end
   end

   // Register the strobe and done outputs so downstream enables get no glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_reg    <= 8'h00;
         done_reg <= 1'b0;
      end else begin
         y_reg    <= y_next;
         done_reg <= done_next;
      end
   end

   assign Y_out     = y_reg;
   assign done      = done_reg;
   assign ready_out = ~hold_valid_reg;
   assign busy      = (state_reg != IDLE) | hold_valid_reg;

endmodule

// File: tb/tb_decoder3to8_pulse.sv
// Testbench for decoder3to8_pulse. Three instances with different
// pulse/gap lengths run side by side against a timeline model. For every
// accepted code, the model works out the strobe start edge and writes the
// expected output values for each future cycle into arrays.

module tb_decoder3to8_pulse;

   localparam int ND  = 3;
   localparam int NC  = 8192;
   localparam int P_A = 4;
   localparam int G_A = 1;
   localparam int P_B = 2;
   localparam int G_B = 0;
   localparam int P_C = 1;
   localparam int G_C = 3;

   typedef struct {
      int         s;
      logic [2:0] code;
   } strobe_t;

   typedef struct {
      logic [2:0] code;
      logic [7:0] y;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_s   [ND];
   logic [2:0] code_s  [ND];
   logic       valid_s [ND];
   logic       ready_s [ND];
   logic [7:0] y_s     [ND];
   logic       busy_s  [ND];
   logic       done_s  [ND];

   decoder3to8_pulse #(.PULSE_LEN(P_A), .GAP_LEN(G_A)) dut_a (
      .clk(clk), .rst(rst_s[0]), .code_in(code_s[0]), .valid_in(valid_s[0]),
      .ready_out(ready_s[0]), .Y_out(y_s[0]), .busy(busy_s[0]), .done(done_s[0]));

   decoder3to8_pulse #(.PULSE_LEN(P_B), .GAP_LEN(G_B)) dut_b (
      .clk(clk), .rst(rst_s[1]), .code_in(code_s[1]), .valid_in(valid_s[1]),
      .ready_out(ready_s[1]), .Y_out(y_s[1]), .busy(busy_s[1]), .done(done_s[1]));

   decoder3to8_pulse #(.PULSE_LEN(P_C), .GAP_LEN(G_C)) dut_c (
      .clk(clk), .rst(rst_s[2]), .code_in(code_s[2]), .valid_in(valid_s[2]),
      .ready_out(ready_s[2]), .Y_out(y_s[2]), .busy(busy_s[2]), .done(done_s[2]));

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;

   // Timeline model: expected outputs after edge k are held in the arrays at index k.
   int         free_t [ND];
   int         pop_e  [ND];
   logic [7:0] ey [ND][NC];
   logic       ed [ND][NC];
   logic       eb [ND][NC];
   logic       er [ND][NC];
   int         acc_n  [ND];
   int         done_n [ND];
   strobe_t    exp_q [ND][$];
   strobe_t    obs_q [ND][$];
   logic [7:0] prev_y [ND];
   logic       prev_d [ND];

   function automatic int plen(input int d);
      case (d)
         0:       return P_A;
         1:       return P_B;
         default: return P_C;
      endcase
   endfunction

   function automatic int glen(input int d);
      case (d)
         0:       return G_A;
         1:       return G_B;
         default: return G_C;
      endcase
   endfunction

   function automatic logic [2:0] enc(input logic [7:0] y);
      logic [2:0] r = 3'd0;
      for (int i = 0; i < 8; i++) if (y[i]) r = 3'(i);
      return r;
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp_v);
      n_assert++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, d, cyc, act, exp_v);
      end
   endtask

   task automatic model_step();
      int k, p, g, s;
      strobe_t st;
      cyc++;
      k = cyc;
      for (int d = 0; d < ND; d++) begin
         p = plen(d);
         g = glen(d);
         if (rst_s[d]) begin
            free_t[d] = 0;
            pop_e[d]  = -1;
            for (int i = k; i < k + 64; i++) begin
               ey[d][i] = 8'h00; ed[d][i] = 1'b0; eb[d][i] = 1'b0; er[d][i] = 1'b1;
            end
            for (int j = exp_q[d].size() - 1; j >= 0; j--)
               if (exp_q[d][j].s >= k) exp_q[d].delete(j);
         end else if (valid_s[d] && pop_e[d] < k) begin
            // Strobe starts at the next edge, or when the previous strobe plus its gap has finished.
            s = (free_t[d] > k + 1) ? free_t[d] : k + 1;
            for (int i = k; i < s; i++) begin er[d][i] = 1'b0; eb[d][i] = 1'b1; end
            for (int i = s; i < s + p; i++) begin ey[d][i] = 8'h01 << code_s[d]; eb[d][i] = 1'b1; end
            ed[d][s + p - 1] = 1'b1;
            for (int i = s + p; i < s + p + g; i++) eb[d][i] = 1'b1;
            pop_e[d]  = s;
            free_t[d] = s + p + g;
            st.s = s;
            st.code = code_s[d];
            exp_q[d].push_back(st);
            acc_n[d]++;
         end
      end
   endtask

   // Model process: initialise the arrays, then advance one step per rising edge.
   initial begin
      for (int d = 0; d < ND; d++) begin
         free_t[d] = 0; pop_e[d] = -1; acc_n[d] = 0; done_n[d] = 0;
         prev_y[d] = 8'h00; prev_d[d] = 1'b0;
         for (int i = 0; i < NC; i++) begin
            ey[d][i] = 8'h00; ed[d][i] = 1'b0; eb[d][i] = 1'b0; er[d][i] = 1'b1;
         end
      end
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Per-cycle checker on the falling edge; also records each observed strobe start.
   initial begin
      strobe_t st;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            for (int d = 0; d < ND; d++) begin
               chk("Y_out",  d, 32'(y_s[d]),           32'(ey[d][cyc]));
               chk("done",   d, 32'(done_s[d]),        32'(ed[d][cyc]));
               chk("busy",   d, 32'(busy_s[d]),        32'(eb[d][cyc]));
               chk("ready",  d, 32'(ready_s[d]),       32'(er[d][cyc]));
               chk("onehot", d, 32'($onehot0(y_s[d])), 32'd1);
               if (done_s[d]) done_n[d]++;
               if (y_s[d] != 8'h00 && (prev_y[d] == 8'h00 || prev_d[d])) begin
                  st.s = cyc;
                  st.code = enc(y_s[d]);
                  obs_q[d].push_back(st);
               end
               prev_y[d] = y_s[d];
               prev_d[d] = done_s[d];
            end
         end
      end
   end

   // Present one code and keep valid high until the model says it has been taken.
   task automatic send(input int d, input logic [2:0] c, input bit keep);
      int n = 0;
      code_s[d]  = c;
      valid_s[d] = 1'b1;
      while (!er[d][cyc] && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         n_assert++; n_fail++;
         $display("FAIL send_timeout dut%0d: ready not seen, required 1 within 100 cycles", d);
      end
      @(negedge clk);
      $display("accept dut%0d code %0d at edge %0d", d, c, cyc);
      if (!keep) valid_s[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      while (eb[d][cyc] && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         n_assert++; n_fail++;
         $display("FAIL idle_timeout dut%0d: still busy, required idle within 100 cycles", d);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl [8];
      int         d0, a0, n;
      logic [2:0] last;

      for (int d = 0; d < ND; d++) begin
         rst_s[d] = 1'b1; valid_s[d] = 1'b0; code_s[d] = 3'd0;
      end
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      for (int d = 0; d < ND; d++) begin
         chk("rst_Y",     d, 32'(y_s[d]),     32'h0);
         chk("rst_ready", d, 32'(ready_s[d]), 32'h1);
         chk("rst_busy",  d, 32'(busy_s[d]),  32'h0);
         chk("rst_done",  d, 32'(done_s[d]),  32'h0);
         rst_s[d] = 1'b0;
      end
      @(negedge clk);

      // Test 1: a single code 5 gives 4 cycles of 0x20, then one gap cycle.
      send(0, 3'd5, 1'b0);
      chk("t1_ready", 0, 32'(ready_s[0]), 32'h0);
      chk("t1_busy",  0, 32'(busy_s[0]),  32'h1);
      chk("t1_Y0",    0, 32'(y_s[0]),     32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_Y",    0, 32'(y_s[0]),    32'h20);
         chk("t1_done", 0, 32'(done_s[0]), (i == 3) ? 32'h1 : 32'h0);
      end
      @(negedge clk);
      chk("t1_gapY",    0, 32'(y_s[0]),    32'h0);
      chk("t1_gapbusy", 0, 32'(busy_s[0]), 32'h1);
      @(negedge clk);
      chk("t1_idlebusy", 0, 32'(busy_s[0]), 32'h0);

      // Test 2: stream 0, 7, 3 with valid held high.
      wait_idle(0);
      send(0, 3'd0, 1'b1);
      send(0, 3'd7, 1'b1);
      send(0, 3'd3, 1'b0);
      wait_idle(0);

      // Test 3: with no gap, queued codes 2 and 6 run back to back with no zero cycle.
      wait_idle(1);
      send(1, 3'd2, 1'b1);
      send(1, 3'd6, 1'b0);
      chk("t3_Y_a",    1, 32'(y_s[1]),    32'h04);
      chk("t3_done_a", 1, 32'(done_s[1]), 32'h1);
      @(negedge clk);
      chk("t3_Y_b",    1, 32'(y_s[1]),    32'h40);
      chk("t3_done_b", 1, 32'(done_s[1]), 32'h0);
      @(negedge clk);
      chk("t3_Y_c",    1, 32'(y_s[1]),    32'h40);
      chk("t3_done_c", 1, 32'(done_s[1]), 32'h1);
      @(negedge clk);
      chk("t3_Y_d",    1, 32'(y_s[1]),    32'h0);

      // Test 4: reset in the second cycle of strobe 1, while code 4 is queued.
      wait_idle(0);
      send(0, 3'd1, 1'b1);
      send(0, 3'd4, 1'b0);
      chk("t4_Y_pre", 0, 32'(y_s[0]), 32'h02);
      rst_s[0] = 1'b1;
      @(negedge clk);
      rst_s[0] = 1'b0;
      chk("t4_Y",     0, 32'(y_s[0]),     32'h0);
      chk("t4_ready", 0, 32'(ready_s[0]), 32'h1);
      chk("t4_busy",  0, 32'(busy_s[0]),  32'h0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("t4_no_code4", 0, 32'(y_s[0] == 8'h10), 32'h0);
      end

      // Test 5: valid stays high while ready is low and code_in keeps changing.
      // Only the code present on the accepting edge may come out.
      send(0, 3'd2, 1'b0);
      send(0, 3'd6, 1'b0);
      valid_s[0] = 1'b1;
      n = 0;
      forever begin
         code_s[0] = 3'($urandom_range(0, 5));
         if (er[0][cyc] || n >= 100) break;
         @(negedge clk);
         n++;
      end
      last = code_s[0];
      @(negedge clk);
      valid_s[0] = 1'b0;
      $display("accept dut0 code %0d after %0d stalled cycles", last, n);
      n = 0;
      while ((y_s[0] == 8'h00 || y_s[0] == 8'h40) && n < 60) begin @(negedge clk); n++; end
      chk("t5_Y", 0, 32'(y_s[0]), 32'(8'h01 << last));

      // Test 6: table of all eight codes sent one at a time.
      tbl[0] = '{3'd0, 8'h01}; tbl[1] = '{3'd1, 8'h02};
      tbl[2] = '{3'd2, 8'h04}; tbl[3] = '{3'd3, 8'h08};
      tbl[4] = '{3'd4, 8'h10}; tbl[5] = '{3'd5, 8'h20};
      tbl[6] = '{3'd6, 8'h40}; tbl[7] = '{3'd7, 8'h80};
      wait_idle(0);
      d0 = done_n[0];
      a0 = acc_n[0];
      for (int i = 0; i < 8; i++) begin
         wait_idle(0);
         send(0, tbl[i].code, 1'b0);
         @(negedge clk);
         chk("t6_Y", 0, 32'(y_s[0]), 32'(tbl[i].y));
      end
      wait_idle(0);
      chk("t6_done_count", 0, 32'(done_n[0] - d0), 32'(acc_n[0] - a0));

      // Random traffic on all three instances, with an occasional reset.
      for (int c = 0; c < 1500; c++) begin
         for (int d = 0; d < ND; d++) begin
            rst_s[d]   = ($urandom_range(0, 99) == 0);
            valid_s[d] = ($urandom_range(0, 2) != 0);
            code_s[d]  = 3'($urandom_range(0, 7));
         end
         @(negedge clk);
      end
      for (int d = 0; d < ND; d++) begin
         rst_s[d] = 1'b0; valid_s[d] = 1'b0;
      end
      repeat (70) @(negedge clk);

      // Strobes must have come out in the order they were accepted, at the predicted edges.
      for (int d = 0; d < ND; d++) begin
         chk("order_len", d, 32'(obs_q[d].size()), 32'(exp_q[d].size()));
         for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
            chk("order_start", d, 32'(obs_q[d][i].s),    32'(exp_q[d][i].s));
            chk("order_code",  d, 32'(obs_q[d][i].code), 32'(exp_q[d][i].code));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
